// File: rtl/icmp_pkg.sv
// -----------------------------------------------------------------------------
// icmp_pkg
// Shared definitions for the ICMP echo payload buffer.
//   - buf_state_e      : sequencing FSM states (IDLE, WRITE, DROP, HOLD, READ)
//   - ICMP_BUF_ADDR_W  : payload RAM address width (2^11 = 2048 bytes)
//   - ICMP_BUF_DATA_W  : payload byte width
//   - ICMP_DROP_CNT_W  : width of the optional discarded-packet counter
//   - drop_cnt_inc     : saturating increment for that counter
// -----------------------------------------------------------------------------
package icmp_pkg;

   localparam int ICMP_BUF_ADDR_W = 11;
   localparam int ICMP_BUF_DATA_W = 8;
   localparam int ICMP_DROP_CNT_W = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      DROP  = 3'd2,
      HOLD  = 3'd3,
      READ  = 3'd4
   } buf_state_e;

   // Saturating increment: the counter sticks at all-ones instead of wrapping.
   function automatic logic [ICMP_DROP_CNT_W-1:0] drop_cnt_inc(
      input logic [ICMP_DROP_CNT_W-1:0] value
   );
      return (&value) ? value : value + ICMP_DROP_CNT_W'(1);
   endfunction

endpackage : icmp_pkg

// File: rtl/icmp_buf_rd_skid.sv
// -----------------------------------------------------------------------------
// icmp_buf_rd_skid
// Two-entry output skid for the payload readout. It absorbs the one-cycle RAM
// read latency while tx_ready is low, and grants read-address issue credit so
// that the skid can never be overrun: every issued address is guaranteed a
// slot when its data returns one cycle later.
//
// Ports
//   clk, rst_n      : clock, synchronous active-low reset
//   issue           : a RAM read address is presented this cycle
//   issue_last      : the address being issued is the final payload byte
//   ram_rd_data     : RAM read data, valid the cycle after issue
//   tx_ready        : downstream accepts the head byte
//   credit_ok       : an address may be issued this cycle
//   tx_valid        : head entry is valid
//   tx_data         : head entry byte (registered)
//   tx_last         : head entry is the final byte (qualified by tx_valid)
// -----------------------------------------------------------------------------
module icmp_buf_rd_skid
   import icmp_pkg::*;
#(
   parameter int DATA_W = ICMP_BUF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue,
   input  logic              issue_last,
   input  logic [DATA_W-1:0] ram_rd_data,
   input  logic              tx_ready,
   output logic              credit_ok,
   output logic              tx_valid,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_last
);

   // A read issued last cycle whose data is on ram_rd_data now.
   logic              pend_q;
   logic              pend_last_q;

   // Entry count (0..2); head drives the outputs, tail is the skid slot.
   logic [1:0]        cnt_q;
   logic [DATA_W-1:0] head_data_q;
   logic              head_last_q;
   logic [DATA_W-1:0] tail_data_q;
   logic              tail_last_q;

   logic              push;
   logic              pop;
   logic [2:0]        occupancy;

   assign tx_valid = (cnt_q != 2'd0);
   assign tx_data  = head_data_q;
   assign tx_last  = head_last_q && tx_valid;

   assign push = pend_q;
   assign pop  = tx_valid && tx_ready;

   // Entries that will still be held next cycle, counting the byte in flight
   // from the RAM. A new issue is allowed only while this leaves a free slot.
   assign occupancy = {1'b0, cnt_q} + {2'b00, pend_q} - {2'b00, pop};
   assign credit_ok = (occupancy < 3'd2);

   // NOTE: sequential state is assigned with <= so every flop samples the
   // pre-edge values; blocking = here would make results order-dependent.
   // NOTE: these data registers are reset because they drive tx_data, which
   // must read 0 out of reset; the payload RAM itself is never reset, its
   // contents only become meaningful once pkt_avail/payload_len say so.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_q      <= 1'b0;
         pend_last_q <= 1'b0;
         cnt_q       <= 2'd0;
         head_data_q <= '0;
         head_last_q <= 1'b0;
         tail_data_q <= '0;
         tail_last_q <= 1'b0;
      end else begin
         pend_q      <= issue;
         pend_last_q <= issue && issue_last;

         case ({push, pop})
            2'b10: begin
               if (cnt_q == 2'd0) begin
                  head_data_q <= ram_rd_data;
                  head_last_q <= pend_last_q;
               end else begin
                  tail_data_q <= ram_rd_data;
                  tail_last_q <= pend_last_q;
               end
               cnt_q <= cnt_q + 2'd1;
            end
            2'b01: begin
               // Tail moves up; with one entry this copies a stale slot into
               // an empty head, which tx_valid masks.
               head_data_q <= tail_data_q;
               head_last_q <= tail_last_q;
               cnt_q       <= cnt_q - 2'd1;
            end
            2'b11: begin
               if (cnt_q == 2'd2) begin
                  head_data_q <= tail_data_q;
                  head_last_q <= tail_last_q;
                  tail_data_q <= ram_rd_data;
                  tail_last_q <= pend_last_q;
               end else begin
                  head_data_q <= ram_rd_data;
                  head_last_q <= pend_last_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule : icmp_buf_rd_skid

// File: rtl/icmp_payload_buf_ctrl.sv
// -----------------------------------------------------------------------------
// icmp_payload_buf_ctrl
// Sequencing controller for the ICMP echo payload buffer (simple dual-port
// RAM instantiated one level up). Writes one received echo-request payload
// into the RAM, records its length, holds it until the reply builder asks for
// it, then streams it back out with valid/ready backpressure.
//
// Optional feature: define ICMP_BUF_DROP_CNT_EN to add the drop_cnt output, a
// saturating count of discarded packets (rx_err, overflow, or rx_start while
// a packet is held or being read).
//
// Ports
//   clk, rst_n                           : clock, synchronous active-low reset
//   rx_start/rx_valid/rx_data/rx_last    : payload stream from the RX parser
//   rx_err                               : discard the packet being written
//   tx_req                               : reply builder requests the payload
//   tx_ready/tx_valid/tx_data/tx_last    : payload stream to the TX builder
//   pkt_avail                            : complete payload stored, not read
//   payload_len                          : stored byte count, 1..2^ADDR_W
//   ram_wr_en/ram_wr_addr/ram_wr_data    : RAM write port (registered)
//   ram_rd_addr/ram_rd_data              : RAM read port, 1-cycle latency
//   drop_cnt (ICMP_BUF_DROP_CNT_EN only) : discarded-packet counter
// -----------------------------------------------------------------------------
module icmp_payload_buf_ctrl
   import icmp_pkg::*;
#(
   parameter int ADDR_W = ICMP_BUF_ADDR_W,
   parameter int DATA_W = ICMP_BUF_DATA_W,
   parameter int LEN_W  = ADDR_W + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_start,
   input  logic              rx_valid,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_last,
   input  logic              rx_err,
   input  logic              tx_req,
   input  logic              tx_ready,
   output logic              tx_valid,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_last,
   output logic              pkt_avail,
   output logic [LEN_W-1:0]  payload_len,
   output logic              ram_wr_en,
   output logic [ADDR_W-1:0] ram_wr_addr,
   output logic [DATA_W-1:0] ram_wr_data,
   output logic [ADDR_W-1:0] ram_rd_addr,
   input  logic [DATA_W-1:0] ram_rd_data
`ifdef ICMP_BUF_DROP_CNT_EN
   ,
   output logic [ICMP_DROP_CNT_W-1:0] drop_cnt
`endif
);

   localparam logic [LEN_W-1:0] BUF_DEPTH = LEN_W'(2 ** ADDR_W);

   buf_state_e       state_q;
   buf_state_e       state_d;

   // Pointers are one bit wider than the RAM address so that "full"
   // (write side) and "past the end" (read side) are representable.
   logic [LEN_W-1:0] wr_ptr_q;
   logic [LEN_W-1:0] rd_ptr_q;

   logic             wr_clear;
   logic             wr_fire;
   logic             len_load;
   logic             buf_full;
   logic             rd_issue;
   logic             rd_issue_last;
   logic             credit_ok;
   logic             tx_done;

   assign buf_full      = (wr_ptr_q == BUF_DEPTH);
   assign tx_done       = tx_valid && tx_ready && tx_last;
   assign rd_issue      = (state_q == READ) && (rd_ptr_q < payload_len) && credit_ok;
   assign rd_issue_last = (rd_ptr_q == payload_len - LEN_W'(1));
   assign ram_rd_addr   = rd_ptr_q[ADDR_W-1:0];

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every signal written here gets a default first, so no path through
   // the case can leave one unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      wr_clear = 1'b0;
      wr_fire  = 1'b0;
      len_load = 1'b0;

      case (state_q)
         IDLE: begin
            // tx_req is deliberately not looked at here.
            if (rx_start) begin
               state_d  = WRITE;
               wr_clear = 1'b1;
            end
         end

         WRITE: begin
            // Error wins over everything, including a byte carrying rx_last.
            if (rx_err) begin
               state_d = IDLE;
            end else if (rx_start) begin
               wr_clear = 1'b1;
            end else if (rx_valid) begin
               if (buf_full) begin
                  state_d = DROP;
               end else begin
                  wr_fire = 1'b1;
                  if (rx_last) begin
                     len_load = 1'b1;
                     state_d  = HOLD;
                  end
               end
            end
         end

         DROP: begin
            if (rx_start) begin
               state_d  = WRITE;
               wr_clear = 1'b1;
            end else if (rx_valid && rx_last) begin
               state_d = IDLE;
            end
         end

         HOLD: begin
            // rx_start is dropped here; the stored packet is never touched.
            if (tx_req) begin
               state_d = READ;
            end
         end

         READ: begin
            if (tx_done) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         ram_wr_en   <= 1'b0;
         ram_wr_addr <= '0;
         ram_wr_data <= '0;
         payload_len <= '0;
         pkt_avail   <= 1'b0;
      end else begin
         if (wr_clear) begin
            wr_ptr_q <= '0;
         end else if (wr_fire) begin
            wr_ptr_q <= wr_ptr_q + LEN_W'(1);
         end

         ram_wr_en <= wr_fire;
         if (wr_fire) begin
            ram_wr_addr <= wr_ptr_q[ADDR_W-1:0];
            ram_wr_data <= rx_data;
         end

         if (len_load) begin
            payload_len <= wr_ptr_q + LEN_W'(1);
         end

         // Raised from the first HOLD cycle, so it trails the last byte by two
         // cycles and lines up with the final ram_wr_* beat having landed.
         if (tx_done) begin
            pkt_avail <= 1'b0;
         end else if (state_q == HOLD) begin
            pkt_avail <= 1'b1;
         end

         // Parked at 0 outside READ so address 0 is on the bus the cycle
         // after tx_req.
         if (state_q != READ) begin
            rd_ptr_q <= '0;
         end else if (rd_issue) begin
            rd_ptr_q <= rd_ptr_q + LEN_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Output skid
   // ---------------------------------------------------------------------------
   icmp_buf_rd_skid #(
      .DATA_W (DATA_W)
   ) u_rd_skid (
      .clk         (clk),
      .rst_n       (rst_n),
      .issue       (rd_issue),
      .issue_last  (rd_issue_last),
      .ram_rd_data (ram_rd_data),
      .tx_ready    (tx_ready),
      .credit_ok   (credit_ok),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_last     (tx_last)
   );

`ifdef ICMP_BUF_DROP_CNT_EN
   // ---------------------------------------------------------------------------
   // Discarded-packet counter
   // ---------------------------------------------------------------------------
   logic drop_evt;

   // Mirrors the WRITE priority above: an overflow only counts when the byte
   // is not pre-empted by rx_err or rx_start.
   assign drop_evt = ((state_q == WRITE) &&
                      (rx_err || (!rx_start && rx_valid && buf_full))) ||
                     (((state_q == HOLD) || (state_q == READ)) && rx_start);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (drop_evt) begin
         drop_cnt <= drop_cnt_inc(drop_cnt);
      end
   end
`endif

endmodule : icmp_payload_buf_ctrl

// File: tb/tb_icmp_payload_buf_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icmp_payload_buf_ctrl
// Self-checking bench for icmp_payload_buf_ctrl. Models the external RAM and
// keeps a packet-level reference: the bytes expected to be stored, whether a
// packet is held, and how many packets have been discarded. Honours
// ICMP_BUF_DROP_CNT_EN when defined.
// -----------------------------------------------------------------------------
module tb_icmp_payload_buf_ctrl;

   localparam int DEPTH = 2048;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic        rx_start = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data  = 8'h00;
   logic        rx_last  = 1'b0;
   logic        rx_err   = 1'b0;
   logic        tx_req   = 1'b0;
   logic        tx_ready = 1'b0;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_last;
   logic        pkt_avail;
   logic [11:0] payload_len;
   logic        ram_wr_en;
   logic [10:0] ram_wr_addr;
   logic [7:0]  ram_wr_data;
   logic [10:0] ram_rd_addr;
   logic [7:0]  ram_rd_data;
`ifdef ICMP_BUF_DROP_CNT_EN
   logic [15:0] drop_cnt;
`endif

   logic [7:0]  ram [0:DEPTH-1];

   always #5 clk = ~clk;

   icmp_payload_buf_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_start    (rx_start),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .rx_last     (rx_last),
      .rx_err      (rx_err),
      .tx_req      (tx_req),
      .tx_ready    (tx_ready),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_last     (tx_last),
      .pkt_avail   (pkt_avail),
      .payload_len (payload_len),
      .ram_wr_en   (ram_wr_en),
      .ram_wr_addr (ram_wr_addr),
      .ram_wr_data (ram_wr_data),
      .ram_rd_addr (ram_rd_addr),
      .ram_rd_data (ram_rd_data)
`ifdef ICMP_BUF_DROP_CNT_EN
      ,
      .drop_cnt    (drop_cnt)
`endif
   );

   // Simple dual-port RAM: synchronous write, read data one cycle after the
   // address, no output register.
   always @(posedge clk) begin
      if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
      ram_rd_data <= ram[ram_rd_addr];
   end

   // Reference state
   int         n_checks   = 0;
   int         n_errors   = 0;
   bit         held       = 1'b0;
   int         exp_len    = 0;
   int         exp_drops  = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_drops(input string tag);
`ifdef ICMP_BUF_DROP_CNT_EN
      check(tag, drop_cnt, exp_drops);
`endif
   endtask

   task automatic check_reset_outputs();
      check("rst_tx_valid",    tx_valid,    0);
      check("rst_tx_last",     tx_last,     0);
      check("rst_tx_data",     tx_data,     0);
      check("rst_pkt_avail",   pkt_avail,   0);
      check("rst_payload_len", payload_len, 0);
      check("rst_wr_en",       ram_wr_en,   0);
      check("rst_wr_addr",     ram_wr_addr, 0);
      check("rst_wr_data",     ram_wr_data, 0);
      check("rst_rd_addr",     ram_rd_addr, 0);
      check_drops("rst_drop_cnt");
   endtask

   // Pulses tx_req and counts tx_valid cycles; used where tx_req must be ignored.
   task automatic expect_no_tx(input string tag, input int cycles);
      int seen = 0;
      tx_ready = 1'b1;
      tx_req   = 1'b1;
      tick();
      tx_req = 1'b0;
      for (int c = 0; c < cycles; c++) begin
         if (tx_valid) seen++;
         tick();
      end
      tx_ready = 1'b0;
      check(tag, seen, 0);
   endtask

   // Sends one packet of len bytes. err_at: byte index carrying rx_err (-1 none,
   // sending stops there). restart_at: byte index preceded by a second rx_start.
   task automatic send_pkt(input int len, input int err_at, input int restart_at,
                           input bit pattern, input bit gaps);
      logic [7:0] q[$];
      logic [7:0] b;
      bit         busy    = held;
      bit         dropped = 1'b0;
      bit         will_write;
      int         wr_idx  = 0;

      rx_start = 1'b1;
      if (busy) exp_drops++;
      tick();
      rx_start = 1'b0;

      for (int i = 0; i < len; i++) begin
         if (i == restart_at) begin
            rx_start = 1'b1;
            tick();
            rx_start = 1'b0;
            q.delete();
            wr_idx = 0;
         end
         if (gaps && $urandom_range(0, 3) == 0) begin
            tick();
            check("wr_gap_en", ram_wr_en, 0);
         end
         b = pattern ? 8'(i) : 8'($urandom);
         will_write = !busy && !dropped && (wr_idx < DEPTH) && (i != err_at);
         if (!busy && !dropped && (i == err_at || wr_idx == DEPTH)) begin
            dropped = 1'b1;
            exp_drops++;
         end
         rx_valid = 1'b1;
         rx_data  = b;
         rx_last  = (i == len - 1);
         rx_err   = (i == err_at);
         tick();
         rx_valid = 1'b0;
         rx_last  = 1'b0;
         rx_err   = 1'b0;
         check("wr_en", ram_wr_en, will_write);
         if (will_write) begin
            check("wr_addr", ram_wr_addr, wr_idx);
            check("wr_data", ram_wr_data, b);
            q.push_back(b);
            wr_idx++;
         end
         if (i == err_at) break;
      end

      // One cycle after the final byte: a fresh packet is not yet announced.
      check("avail_n1", pkt_avail, busy);
      tick();
      if (!busy && !dropped) begin
         held    = 1'b1;
         exp_q   = q;
         exp_len = q.size();
      end
      check("avail_n2", pkt_avail, held);
      if (held) check("payload_len", payload_len, exp_len);
      check_drops("drop_cnt_rx");
   endtask

   // Reads the held packet. rand_ready: random tx_ready, otherwise held high.
   // rxstart_at: cycle (after tx_req) carrying an rx_start to be dropped.
   // rst_at: byte index during which rst_n is pulsed low (-1 none).
   task automatic read_pkt(input bit rand_ready, input int rxstart_at, input int rst_at);
      int         n_got     = 0;
      int         cyc       = 0;
      int         first_cyc = -1;
      int         last_cyc  = -1;
      int         budget    = 8 * exp_len + 64;
      bit         stall     = 1'b0;
      logic [7:0] sd        = 8'h00;
      logic       sl        = 1'b0;

      tx_req = 1'b1;
      tick();
      tx_req = 1'b0;
      cyc    = 1;
      check("rd_addr_first", ram_rd_addr, 0);

      while (n_got < exp_len && cyc < budget) begin
         if (stall) begin
            check("stall_valid", tx_valid, 1);
            check("stall_data",  tx_data,  sd);
            check("stall_last",  tx_last,  sl);
         end
         if (rst_at >= 0 && n_got == rst_at && tx_valid) begin
            rst_n = 1'b0;
            tick();
            rst_n     = 1'b1;
            tx_ready  = 1'b0;
            held      = 1'b0;
            exp_len   = 0;
            exp_drops = 0;
            exp_q.delete();
            check_reset_outputs();
            return;
         end
         tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (cyc == rxstart_at) begin
            rx_start = 1'b1;
            exp_drops++;
         end
         if (tx_valid && first_cyc < 0) first_cyc = cyc;
         if (tx_valid && tx_ready) begin
            check("rd_data", tx_data, exp_q[n_got]);
            check("rd_last", tx_last, (n_got == exp_len - 1));
            n_got++;
            last_cyc = cyc;
         end else if (!tx_valid) begin
            check("idle_last", tx_last, 0);
         end
         stall = tx_valid && !tx_ready;
         sd    = tx_data;
         sl    = tx_last;
         tick();
         rx_start = 1'b0;
         cyc++;
      end
      tx_ready = 1'b0;

      check("rd_count", n_got, exp_len);
      if (!rand_ready) begin
         check("rd_first_cyc", first_cyc, 3);
         check("rd_last_cyc",  last_cyc,  exp_len + 2);
      end
      check("rd_avail_clr", pkt_avail, 0);
      check("rd_valid_clr", tx_valid, 0);
      held = 1'b0;
      check_drops("drop_cnt_rd");
   endtask

   initial begin
      int len;
      int err;

      rst_n = 1'b0;
      repeat (3) tick();
      check_reset_outputs();
      rst_n = 1'b1;
      tick();

      // tx_req with nothing stored
      expect_no_tx("idle_txreq", 8);

      // Basic echo: 0x00..0x3F, ready high
      send_pkt(64, -1, -1, 1'b1, 1'b0);
      read_pkt(1'b0, -1, -1);

      // Single-byte payload
      send_pkt(1, -1, -1, 1'b0, 1'b0);
      read_pkt(1'b0, -1, -1);

      // Backpressure
      for (int k = 0; k < 4; k++) begin
         len = (k == 0) ? 10 : int'($urandom_range(2, 40));
         send_pkt(len, -1, -1, 1'b0, 1'b1);
         read_pkt(1'b1, -1, -1);
      end

      // Error discard on byte 5, then on the rx_last byte
      send_pkt(12, 5, -1, 1'b0, 1'b0);
      expect_no_tx("err_idle", 6);
      send_pkt(6, 5, -1, 1'b0, 1'b1);
      expect_no_tx("err_last_idle", 6);

      // Restart in WRITE: only bytes 5..11 survive
      send_pkt(12, -1, 5, 1'b1, 1'b0);
      read_pkt(1'b1, -1, -1);

      // Overflow, then a normal packet straight out of DROP
      send_pkt(DEPTH + 1, -1, -1, 1'b0, 1'b0);
      expect_no_tx("ovf_no_tx", 6);
      send_pkt(9, -1, -1, 1'b0, 1'b0);
      read_pkt(1'b1, -1, -1);

      // Exactly full buffer
      send_pkt(DEPTH, -1, -1, 1'b0, 1'b0);
      read_pkt(1'b0, -1, -1);

      // Busy drop while held, and an rx_start during READ
      send_pkt(12, -1, -1, 1'b0, 1'b0);
      send_pkt(20, -1, -1, 1'b0, 1'b1);
      read_pkt(1'b1, 2, -1);

      // Reset during byte 3 of 16
      send_pkt(16, -1, -1, 1'b0, 1'b0);
      read_pkt(1'b0, -1, 3);
      expect_no_tx("rst_idle", 6);

      // Randomized traffic
      for (int k = 0; k < 8; k++) begin
         len = int'($urandom_range(1, 100));
         err = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
         send_pkt(len, err, -1, 1'b0, 1'b1);
         if (held) read_pkt(1'($urandom_range(0, 1)), -1, -1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule : tb_icmp_payload_buf_ctrl

// File: doc/icmp_payload_buf_ctrl.md
# icmp_payload_buf_ctrl

Sequencing controller for the ICMP echo payload buffer, an 8-bit × 2048-entry simple dual-port RAM. It writes the payload bytes of one received ICMP echo request into the RAM and records the payload length. It then holds the packet until the echo-reply assembler requests it, and streams the bytes back out with valid/ready backpressure. The block sits between the ICMP RX parser and the ICMP TX reply builder; the RAM is instantiated alongside it, one level up.

## Interface
- ADDR_W, 11, RAM address width; buffer capacity is 2^ADDR_W bytes
- DATA_W, 8, payload byte width
- LEN_W, ADDR_W+1, width of payload_len
- clk  in  1  single clock for the block and both RAM ports
- rst_n  in  1  reset: synchronous, active-low
- rx_start  in  1  one-cycle pulse at the start of an ICMP payload
- rx_valid  in  1  rx_data is valid this cycle
- rx_data  in  DATA_W  payload byte
- rx_last  in  1  final byte; qualified by rx_valid
- rx_err  in  1  discard the current packet (checksum/length error); honoured in WRITE
- tx_req  in  1  one-cycle pulse from the reply builder requesting the stored payload
- tx_ready  in  1  downstream accepts a byte
- tx_valid  out  1  tx_data is valid
- tx_data  out  DATA_W  payload byte
- tx_last  out  1  final byte, coincident with tx_valid
- pkt_avail  out  1  a complete payload is stored and not yet read
- payload_len  out  LEN_W  byte count of the stored payload, range 1..2^ADDR_W
- ram_wr_en, ram_wr_addr[ADDR_W], ram_wr_data[DATA_W]  out  RAM write port
- ram_rd_addr  out  ADDR_W  RAM read address
- ram_rd_data  in  DATA_W  RAM read data; one-cycle latency, no output register

## Operation
- FSM states: IDLE, WRITE, DROP, HOLD, READ.
- **IDLE**
  - rx_start → WRITE; the write pointer clears to 0.
  - tx_req is ignored.
- **WRITE**
  - Each rx_valid byte is written at the write pointer, and the pointer increments.
  - rx_valid && rx_last with no error → HOLD; payload_len is set to the byte count.
  - rx_err, on any cycle including the rx_last cycle → IDLE; no write occurs that cycle.
  - A byte arriving when the pointer equals 2^ADDR_W is an overflow → DROP.
  - rx_start while in WRITE restarts the packet: the pointer returns to 0 and the FSM stays in WRITE.
- **DROP**
  - All bytes are ignored until rx_valid && rx_last, then → IDLE.
  - rx_start while in DROP → WRITE.
- **HOLD**
  - pkt_avail = 1.
  - tx_req → READ.
  - rx_start is ignored and counted as a drop; the stored packet is never overwritten.
- **READ**
  - The read pointer runs 0..payload_len−1, and each address is issued only when the output stage has room.
  - The output stage is a 2-entry skid that absorbs the 1-cycle RAM latency under tx_ready deassertion, so no byte is lost or duplicated.
  - tx_last is asserted on byte payload_len−1.
  - The tx_valid && tx_ready && tx_last handshake → IDLE; pkt_avail clears on the same edge.
  - rx_start during READ is dropped.
- A zero-length payload is never presented; rx_last is always qualified by a byte.
- tx_req outside HOLD is ignored.

## Timing
- **Reset values:** FSM = IDLE; all outputs are 0 (tx_valid, tx_last, pkt_avail, payload_len, ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr); both pointers are 0.
- **Write path**
  - A byte accepted at cycle n appears on ram_wr_* (registered) at cycle n+1.
  - rx_last accepted at n → pkt_avail = 1 at n+2, with payload_len valid at the same time.
- **Read path**
  - tx_req at cycle n → ram_rd_addr = 0 at n+1.
  - tx_valid first asserts at n+3 (1 cycle RAM + 1 cycle output register).
  - With tx_ready held high, one byte per cycle; an L-byte payload completes at n+2+L.
- **Backpressure:** tx_data, tx_last, and tx_valid hold stable while tx_valid && !tx_ready.
- **Reset mid-operation:** rst_n low on any edge returns the block to reset values and discards any stored packet.

## Configuration
- Macro ICMP_BUF_DROP_CNT_EN.
- **Defined:** adds output drop_cnt [15:0]. It increments, saturating at 0xFFFF, once per discarded packet: rx_err, overflow, or rx_start seen in HOLD or READ. Reset value 0.
- **Undefined:** the port and its counter are absent; all other behaviour is identical.

## Structure
- The shared package icmp_pkg holds:
  - the FSM state enum (IDLE, WRITE, DROP, HOLD, READ);
  - ICMP_BUF_ADDR_W = 11 and ICMP_BUF_DATA_W = 8;
  - the drop-counter width.
- One sub-module, icmp_buf_rd_skid: the 2-entry output skid with credit logic that gates read-address issue.

## Test plan
- **Basic echo:** 64-byte payload 0x00..0x3F, tx_ready high → pkt_avail at last+2, payload_len = 64; tx_req gives 64 bytes 0x00..0x3F in order, tx_last on 0x3F, FSM back to IDLE.
- **Backpressure:** 10-byte payload; tx_ready toggled 1,0,0,1,… randomly → output is exactly 10 bytes in order, with no drops or duplicates, and tx_data stable while stalled.
- **Error discard:** rx_err asserted with byte 5 → no pkt_avail, FSM = IDLE, drop_cnt = 1 (if ICMP_BUF_DROP_CNT_EN is defined).
- **Overflow and full buffer:**
  - A 2049-byte packet → DROP, no pkt_avail.
  - An exactly 2048-byte packet → payload_len = 2048; readout wraps cleanly through address 2047.
- **Busy drop:** with a packet held, a new rx_start plus a 20-byte stream → stored packet unchanged on readout, drop_cnt increments.
- **Reset mid-READ:** rst_n low for 1 cycle during byte 3 of 16 → all outputs 0, pkt_avail = 0, FSM = IDLE.
